// File: rtl/telemetry_responder.sv
// Command/response engine between the Bluetooth UART and the telemetry/config fabric.
// Reads return snapshotted channels MSB-first; writes take one argument byte with a timeout.
module telemetry_responder #(
    parameter int unsigned          NUM_CH   = 4,
    parameter int unsigned          CH_WIDTH = 16,
    parameter int unsigned          NUM_CFG  = 2,
    parameter logic [NUM_CFG*8-1:0] CFG_INIT = '0,
    parameter int unsigned          TIMEOUT  = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_byte,
    output logic                       tx_start,
    output logic [7:0]                 tx_byte,
    input  logic                       tx_busy,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    output logic [NUM_CFG*8-1:0]       cfg_data,
    output logic                       cmd_err,
    output logic [7:0]                 drop_count
);

    localparam int unsigned NB     = (CH_WIDTH + 7) / 8;
    localparam int unsigned SH_W   = NB * 8;
    localparam int unsigned LEFT_W = $clog2(NB + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [SH_W-1:0] ACK_REPLY = SH_W'(1) << (SH_W - 8);
    localparam logic [SH_W-1:0] NAK_REPLY = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ARG,
        S_SEND,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic                buf_full_q;
    logic [7:0]          buf_byte_q;
    logic [SH_W-1:0]     shreg_q, shreg_d;
    logic [LEFT_W-1:0]   left_q, left_d;
    logic [NUM_CFG*8-1:0] cfg_q, cfg_d;
    logic [5:0]          cfg_idx_q, cfg_idx_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic                cmd_err_q, err_d;
    logic [7:0]          drop_q;

    logic                pop, push, drop;
    logic [7:0]          opcode;
    logic                ch_ok, cfg_ok;
    logic [CH_WIDTH-1:0] ch_sel;

    assign opcode = buf_byte_q;
    assign pop    = (state_q == S_IDLE) && buf_full_q;
    assign push   = rx_valid && (state_q != S_WAIT_ARG);
    assign drop   = push && buf_full_q && !pop;
    assign ch_ok  = ({1'b0, opcode[5:0]} < 7'(NUM_CH));
    assign cfg_ok = ({1'b0, opcode[5:0]} < 7'(NUM_CFG));

    always_comb begin
        ch_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (opcode[5:0] == 6'(i)) begin
                ch_sel = ch_data[i*CH_WIDTH +: CH_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        left_d    = left_q;
        cfg_d     = cfg_q;
        cfg_idx_d = cfg_idx_q;
        tcnt_d    = tcnt_q;
        err_d     = 1'b0;
        tx_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (opcode[7:6] == 2'b00 && ch_ok) begin
                        shreg_d = SH_W'(ch_sel);
                        left_d  = LEFT_W'(NB);
                        state_d = S_SEND;
                    end else if (opcode[7:6] == 2'b01 && cfg_ok) begin
                        cfg_idx_d = opcode[5:0];
                        tcnt_d    = '0;
                        state_d   = S_WAIT_ARG;
                    end else begin
                        shreg_d = NAK_REPLY;
                        left_d  = LEFT_W'(1);
                        err_d   = 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            S_WAIT_ARG: begin
                // Timeout wins over a byte arriving in the same cycle.
                if (tcnt_q == TO_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    for (int unsigned k = 0; k < NUM_CFG; k++) begin
                        if (cfg_idx_q == 6'(k)) begin
                            cfg_d[k*8 +: 8] = rx_byte;
                        end
                    end
                    shreg_d = ACK_REPLY;
                    left_d  = LEFT_W'(1);
                    state_d = S_SEND;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    shreg_d  = shreg_q << 8;
                    left_d   = left_q - LEFT_W'(1);
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    state_d = (left_q != '0) ? S_SEND : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            buf_full_q <= 1'b0;
            buf_byte_q <= '0;
            shreg_q    <= '0;
            left_q     <= '0;
            cfg_q      <= CFG_INIT;
            cfg_idx_q  <= '0;
            tcnt_q     <= '0;
            cmd_err_q  <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            left_q    <= left_d;
            cfg_q     <= cfg_d;
            cfg_idx_q <= cfg_idx_d;
            tcnt_q    <= tcnt_d;
            cmd_err_q <= err_d;
            if (push && !drop) begin
                buf_full_q <= 1'b1;
                buf_byte_q <= rx_byte;
            end else if (pop) begin
                buf_full_q <= 1'b0;
            end
            if (drop && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign tx_byte    = shreg_q[SH_W-1 -: 8];
    assign cfg_data   = cfg_q;
    assign cmd_err    = cmd_err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_telemetry_responder.sv
// Directed and randomized checks of telemetry_responder against a transaction-level model.
module tb_telemetry_responder;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_WIDTH = 12;
    localparam int unsigned NUM_CFG  = 2;
    localparam int unsigned TIMEOUT  = 100;
    localparam int unsigned NB       = (CH_WIDTH + 7) / 8;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       rx_valid = 1'b0;
    logic [7:0]                 rx_byte = '0;
    logic                       tx_start;
    logic [7:0]                 tx_byte;
    logic                       tx_busy;
    logic [NUM_CH*CH_WIDTH-1:0] ch_data;
    logic [NUM_CFG*8-1:0]       cfg_data;
    logic                       cmd_err;
    logic [7:0]                 drop_count;

    logic [CH_WIDTH-1:0] ch [NUM_CH];
    logic [7:0]          mcfg [NUM_CFG];
    logic [7:0]          exp_q [$];
    logic [7:0]          obs_q [$];
    int unsigned         txc_q [$];
    int unsigned         passed = 0, total = 0, exp_err = 0, err_cnt = 0;
    int unsigned         cyc = 0, busy_cnt = 0, viol = 0, last_cyc = 0;

    telemetry_responder #(
        .NUM_CH  (NUM_CH),
        .CH_WIDTH(CH_WIDTH),
        .NUM_CFG (NUM_CFG),
        .CFG_INIT({8'd200, 8'd26}),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_busy   (tx_busy),
        .ch_data   (ch_data),
        .cfg_data  (cfg_data),
        .cmd_err   (cmd_err),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_data[i*CH_WIDTH +: CH_WIDTH] = ch[i];
    end

    // UART stand-in: busy for 10 cycles starting the cycle after tx_start.
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            obs_q.push_back(tx_byte);
            txc_q.push_back(cyc);
            if (tx_busy) viol <= viol + 1;
        end
        if (cmd_err) err_cnt <= err_cnt + 1;
        if (tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, required finish before 5ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        last_cyc = cyc;
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Expected reply for an opcode, from the opcode map and current channel values.
    task automatic model_opcode(input logic [7:0] op, output bit is_write);
        int unsigned v;
        is_write = 1'b0;
        if (op < 8'h40 && op < NUM_CH) begin
            v = ch[op];
            for (int i = NB - 1; i >= 0; i--) exp_q.push_back(8'((v >> (8 * i)) & 255));
        end else if (op >= 8'h40 && op < 8'h80 && (op - 8'h40) < NUM_CFG) begin
            is_write = 1'b1;
        end else begin
            exp_q.push_back(8'h00);
            exp_err++;
        end
    endtask

    task automatic check_reply(input string tag);
        check({tag, " len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
        txc_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, " cfg"}, cfg_data, {mcfg[1], mcfg[0]});
        check({tag, " err"}, err_cnt, exp_err);
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] arg,
                          input int unsigned dly);
        bit w;
        model_opcode(op, w);
        send_byte(op);
        idle(1);
        for (int i = 0; i < NUM_CH; i++) ch[i] = CH_WIDTH'($urandom);
        if (w) begin
            idle(dly);
            send_byte(arg);
            mcfg[op[5:0]] = arg;
            exp_q.push_back(8'h01);
            check({tag, " cfg next"}, cfg_data, {mcfg[1], mcfg[0]});
        end
        idle(40);
        check_reply(tag);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] orv;
        bit         w;
        int unsigned n;
        for (int i = 0; i < NUM_CH; i++) ch[i] = CH_WIDTH'($urandom);
        mcfg[0] = 8'd26;
        mcfg[1] = 8'd200;

        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        check("rst cfg", cfg_data, 16'hC81A);
        check("rst tx_start", tx_start, 1'b0);
        check("rst tx_byte", tx_byte, 8'h00);
        check("rst drop", drop_count, 8'd0);
        check("rst cmd_err", cmd_err, 1'b0);
        idle(2);

        // Read with snapshot: channel changes after accept must not leak.
        ch[2] = 12'hABC;
        model_opcode(8'h02, w);
        send_byte(8'h02);
        idle(1);
        ch[2] = 12'h123;
        idle(40);
        check("read latency", (txc_q.size() > 0) ? txc_q[0] : 0, last_cyc + 2);
        check("read spacing", (txc_q.size() > 1) ? (txc_q[1] - txc_q[0] >= 12) : 0, 1);
        check_reply("read ch2");
        check_state("read ch2");

        do_cmd("write cfg1", 8'h41, 8'h96, 3);
        check("cfg1 value", cfg_data, 16'h961A);
        do_cmd("write wheel", 8'h40, 8'h1C, 5);
        check("cfg0 value", cfg_data, 16'h961C);

        do_cmd("nak ch5", 8'h05, 8'h00, 1);

        // Invalid write index NAKs immediately; the next byte is an opcode.
        model_opcode(8'h42, w);
        model_opcode(8'h33, w);
        send_byte(8'h42);
        send_byte(8'h33);
        idle(50);
        check_reply("nak 42/33");
        check_state("nak 42/33");

        // Argument on the last allowed cycle is accepted.
        model_opcode(8'h41, w);
        send_byte(8'h41);
        idle(TIMEOUT);
        send_byte(8'h5A);
        mcfg[1] = 8'h5A;
        exp_q.push_back(8'h01);
        check("arg at limit cfg", cfg_data, {mcfg[1], mcfg[0]});
        idle(40);
        check_reply("arg at limit");
        check_state("arg at limit");

        // One cycle later it has already timed out.
        send_byte(8'h40);
        idle(TIMEOUT + 1);
        send_byte(8'h77);
        exp_err++;
        idle(40);
        check_reply("arg late");
        check_state("arg late");

        send_byte(8'h40);
        idle(TIMEOUT + 20);
        exp_err++;
        check_reply("no arg");
        check_state("no arg");

        // Three back-to-back requests: third lands on a full buffer.
        model_opcode(8'h00, w);
        model_opcode(8'h01, w);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(70);
        check_reply("buffer");
        check("buffer drop", drop_count, 8'd1);
        check_state("buffer");

        for (int i = 0; i < 400; i++) send_byte(8'h80 | 8'($urandom));
        idle(60);
        check("drop saturate", drop_count, 8'd255);
        orv = '0;
        foreach (obs_q[i]) orv = orv | obs_q[i];
        check("sat replies", obs_q.size() > 20, 1'b1);
        check("sat nak bytes", orv, 8'h00);
        check("sat err", err_cnt, exp_err + obs_q.size());
        exp_err += obs_q.size();
        obs_q.delete();
        txc_q.delete();

        // Reset between the two bytes of a read.
        ch[2] = CH_WIDTH'($urandom);
        model_opcode(8'h02, w);
        void'(exp_q.pop_back());
        send_byte(8'h02);
        n = 0;
        while (obs_q.size() == 0 && n < 20) begin
            idle(1);
            n++;
        end
        check("rst mid first byte", obs_q.size() > 0, 1'b1);
        idle(2);
        reset = 1'b1;
        idle(1);
        mcfg[0] = 8'd26;
        mcfg[1] = 8'd200;
        check("rst mid tx_start", tx_start, 1'b0);
        check("rst mid tx_byte", tx_byte, 8'h00);
        check("rst mid drop", drop_count, 8'd0);
        check("rst mid cmd_err", cmd_err, 1'b0);
        check("rst mid cfg", cfg_data, 16'hC81A);
        reset = 1'b0;
        idle(40);
        check_reply("rst mid");
        do_cmd("after rst", 8'h01, 8'h00, 1);

        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 4))
                0: op = 8'($urandom_range(0, NUM_CH - 1));
                1: op = 8'($urandom_range(NUM_CH, 63));
                2: op = 8'(8'h40 + $urandom_range(0, NUM_CFG - 1));
                3: op = 8'($urandom_range(8'h40 + NUM_CFG, 8'h7F));
                default: op = 8'($urandom_range(8'h80, 8'hFF));
            endcase
            do_cmd($sformatf("rand%0d op%02h", it, op), op, 8'($urandom),
                   $urandom_range(1, 60));
        end

        check("no tx while busy", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
